// File: rtl/display_tube.sv
`default_nettype none
// ============================================================================
// display_tube: 8-digit multiplexed hex seven-segment driver with a 32-bit
// write-only display register. Rev 1.0
// ============================================================================
module display_tube #(
  parameter int SCAN_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] write_data,
  input  logic        digwrite,
  input  logic        digcs,
  output logic [7:0]  DIG,
  output logic [7:0]  Y
);

  localparam int DC_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DC_W-1:0] c_DC_MAX = DC_W'(SCAN_DIV - 1);

  logic [31:0]     dr_q, dr_d;
  logic [DC_W-1:0] dc_q, dc_d;
  logic [2:0]      si_q, si_d;
  logic [3:0]      nibble;

  always_comb begin
    dr_d = dr_q;
    dc_d = dc_q;
    si_d = si_q;
    if (digcs && digwrite) begin
      dr_d = write_data;
    end
    // With SCAN_DIV=1 the compare is always true, so the index steps every cycle.
    if (dc_q == c_DC_MAX) begin
      dc_d = '0;
      si_d = si_q + 3'd1;
    end else begin
      dc_d = dc_q + DC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dr_q <= '0;
      dc_q <= '0;
      si_q <= '0;
    end else begin
      dr_q <= dr_d;
      dc_q <= dc_d;
      si_q <= si_d;
    end
  end

  assign nibble = dr_q[{si_q, 2'b00} +: 4];
  assign DIG    = ~(8'b1 << si_q);

  always_comb begin
    Y = 8'hFF;
    case (nibble)
      4'h0: Y = 8'hC0;
      4'h1: Y = 8'hF9;
      4'h2: Y = 8'hA4;
      4'h3: Y = 8'hB0;
      4'h4: Y = 8'h99;
      4'h5: Y = 8'h92;
      4'h6: Y = 8'h82;
      4'h7: Y = 8'hF8;
      4'h8: Y = 8'h80;
      4'h9: Y = 8'h90;
      4'hA: Y = 8'h88;
      4'hB: Y = 8'h83;
      4'hC: Y = 8'hC6;
      4'hD: Y = 8'hA1;
      4'hE: Y = 8'h86;
      4'hF: Y = 8'h8E;
      default: Y = 8'hFF;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_display_tube.sv
`default_nettype none
// ============================================================================
// tb_display_tube: randomized and directed checks against a behavioural model.
// Rev 1.0
// ============================================================================
module tb_display_tube;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] write_data = '0;
  logic        digwrite = 1'b0;
  logic        digcs = 1'b0;
  logic [7:0]  DIG, Y, DIG1, Y1;

  int checks = 0;
  int errors = 0;

  int unsigned m_cyc = 0;
  logic [31:0] m_dr  = '0;
  logic [7:0]  seg [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                            8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  always #5 clk = ~clk;

  display_tube #(.SCAN_DIV(4)) dut (
    .clk(clk), .rst(rst), .write_data(write_data), .digwrite(digwrite),
    .digcs(digcs), .DIG(DIG), .Y(Y)
  );

  display_tube #(.SCAN_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .write_data(write_data), .digwrite(digwrite),
    .digcs(digcs), .DIG(DIG1), .Y(Y1)
  );

  // Model: count of non-reset edges since the last reset, plus the register.
  always @(posedge clk) begin
    if (rst) begin
      m_cyc <= 0;
      m_dr  <= '0;
    end else begin
      m_cyc <= m_cyc + 1;
      if (digcs && digwrite) m_dr <= write_data;
    end
  end

  function automatic int digit_of(int div);
    return (m_cyc / div) % 8;
  endfunction

  function automatic logic [7:0] exp_dig(int div);
    return 8'hFF ^ (8'h01 << digit_of(div));
  endfunction

  function automatic logic [7:0] exp_y(int div);
    int n;
    n = (m_dr >> (4 * digit_of(div))) & 32'hF;
    return seg[n];
  endfunction

  task automatic idle();
    rst = 1'b0; digcs = 1'b0; digwrite = 1'b0; write_data = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; digcs = 1'b1; digwrite = 1'b1; write_data = 32'h2;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (DIG !== 8'hFE || Y !== 8'hC0) begin
        errors++;
        $display("FAIL reset_div4 edge %0d: DIG=%h Y=%h, required DIG=fe Y=c0", i, DIG, Y);
      end
      checks++;
      if (DIG1 !== 8'hFE || Y1 !== 8'hC0) begin
        errors++;
        $display("FAIL reset_div1 edge %0d: DIG=%h Y=%h, required DIG=fe Y=c0", i, DIG1, Y1);
      end
    end
  endtask

  task automatic test_scan_digit0();
    rst = 1'b0; digcs = 1'b1; digwrite = 1'b1; write_data = 32'h0000_0002;
    @(negedge clk);
    idle();
    checks++;
    if (DIG !== 8'hFE || Y !== 8'hA4) begin
      errors++;
      $display("FAIL first_write: DIG=%h Y=%h, required DIG=fe Y=a4", DIG, Y);
    end
    for (int i = 0; i < 36; i++) begin
      @(negedge clk);
      checks++;
      if (DIG !== exp_dig(4) || Y !== ((digit_of(4) == 0) ? 8'hA4 : 8'hC0)) begin
        errors++;
        $display("FAIL scan_digit0 cyc %0d: DIG=%h Y=%h, required DIG=%h Y=%h",
                 m_cyc, DIG, Y, exp_dig(4), (digit_of(4) == 0) ? 8'hA4 : 8'hC0);
      end
    end
  endtask

  task automatic test_hex_digits();
    logic [7:0] want [8] = '{8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80};
    logic [7:0] wdig;
    digcs = 1'b1; digwrite = 1'b1; write_data = 32'h89AB_CDEF;
    @(negedge clk);
    idle();
    while (m_cyc % 32 != 0) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      wdig = 8'hFF ^ (8'h01 << k);
      for (int j = 0; j < 4; j++) begin
        checks++;
        if (DIG !== wdig || Y !== want[k]) begin
          errors++;
          $display("FAIL hex_scan digit %0d: DIG=%h Y=%h, required DIG=%h Y=%h",
                   k, DIG, Y, wdig, want[k]);
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_noop();
    for (int i = 0; i < 24; i++) begin
      rst = 1'b0; write_data = 32'hFFFF_FFFF;
      digcs    = (i < 12);
      digwrite = (i >= 12);
      @(negedge clk);
      checks++;
      if (m_dr !== 32'h89AB_CDEF || DIG !== exp_dig(4) || Y !== exp_y(4)) begin
        errors++;
        $display("FAIL noop cs=%0b wr=%0b: DIG=%h Y=%h, required DIG=%h Y=%h",
                 digcs, digwrite, DIG, Y, exp_dig(4), exp_y(4));
      end
    end
    idle();
  endtask

  task automatic test_write_visible();
    digcs = 1'b1; digwrite = 1'b1; write_data = 32'h0;
    @(negedge clk);
    idle();
    while (m_cyc % 32 != 0) @(negedge clk);
    checks++;
    if (DIG !== 8'hFE || Y !== 8'hC0) begin
      errors++;
      $display("FAIL pre_write: DIG=%h Y=%h, required DIG=fe Y=c0", DIG, Y);
    end
    digcs = 1'b1; digwrite = 1'b1; write_data = 32'h0000_0001;
    @(negedge clk);
    idle();
    checks++;
    if (DIG !== 8'hFE || Y !== 8'hF9) begin
      errors++;
      $display("FAIL write_visible: DIG=%h Y=%h, required DIG=fe Y=f9", DIG, Y);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (DIG !== exp_dig(4) || Y !== exp_y(4)) begin
        errors++;
        $display("FAIL write_timing cyc %0d: DIG=%h Y=%h, required DIG=%h Y=%h",
                 m_cyc, DIG, Y, exp_dig(4), exp_y(4));
      end
    end
  endtask

  task automatic test_reset_mid();
    while (m_cyc % 32 != 13) @(negedge clk);
    checks++;
    if (DIG !== 8'hF7) begin
      errors++;
      $display("FAIL mid_scan_pos: DIG=%h, required f7", DIG);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (DIG !== 8'hFE || Y !== 8'hC0) begin
      errors++;
      $display("FAIL reset_mid: DIG=%h Y=%h, required DIG=fe Y=c0", DIG, Y);
    end
    idle();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      checks++;
      if (DIG1 !== (8'hFF ^ (8'h01 << ((i + 1) % 8))) || Y1 !== 8'hC0) begin
        errors++;
        $display("FAIL fast_scan step %0d: DIG=%h Y=%h, required DIG=%h Y=c0",
                 i, DIG1, Y1, 8'hFF ^ (8'h01 << ((i + 1) % 8)));
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      rst        = ($urandom_range(0, 59) == 0);
      digcs      = $urandom_range(0, 1);
      digwrite   = $urandom_range(0, 1);
      write_data = $urandom;
      @(negedge clk);
      checks++;
      if (DIG !== exp_dig(4) || Y !== exp_y(4)) begin
        errors++;
        $display("FAIL random_div4 iter %0d: DIG=%h Y=%h, required DIG=%h Y=%h",
                 i, DIG, Y, exp_dig(4), exp_y(4));
      end
      checks++;
      if (DIG1 !== exp_dig(1) || Y1 !== exp_y(1)) begin
        errors++;
        $display("FAIL random_div1 iter %0d: DIG=%h Y=%h, required DIG=%h Y=%h",
                 i, DIG1, Y1, exp_dig(1), exp_y(1));
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_scan_digit0();
    test_hex_digits();
    test_noop();
    test_write_visible();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
